// File: rtl/lcd_de_rx_timing.sv
// lcd_de_rx_timing
// Receive side of an 800x480 DE-mode RGB565 panel bus. Pixel coordinates and
// frame/line boundaries are recovered from DE alone; HS/VS carry no timing.
// Timing violations are flagged as one-cycle pulses and a lock indicator
// tracks whether the last complete frame was clean.
//
// Optional feature: define LCD_RX_CHECKSUM_EN to build the per-frame 16-bit
// wrapping pixel checksum. Without it frame_sum is tied to zero.
//
// Pipeline: lcd_de/lcd_rgb are registered at edge N, classified and then
// registered onto the outputs at edge N+1 (one lcd_clk of latency).

module lcd_de_rx_timing #(
  parameter logic [10:0] H_DISP     = 11'd800,
  parameter logic [10:0] V_DISP     = 11'd480,
  parameter logic [15:0] VBLANK_THR = 16'd2000
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        lcd_de,
  input  logic [15:0] lcd_rgb,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic        locked,
  output logic [15:0] frame_sum
);

  // Receiver states. SEARCH waits for the first vertical blank after reset so
  // a partially observed frame never raises errors or produces pixels.
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HBLANK = 2'd3;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [15:0] GAP_MAX = 16'hFFFF;

  // Input sample stage and previous DE for edge detection.
  logic        de_q;
  logic        de_prev_q;
  logic [15:0] rgb_q;

  // Timing counters and state.
  logic [15:0] gap_q,   gap_d;
  logic [10:0] hcnt_q,  hcnt_d;
  logic [10:0] vcnt_q,  vcnt_d;
  logic [1:0]  state_q, state_d;
  logic        frame_bad_q, frame_bad_d;

  // Registered outputs.
  logic [15:0] pix_data_q,    pix_data_d;
  logic        pix_valid_q;
  logic [10:0] pix_xpos_q,    pix_xpos_d;
  logic [10:0] pix_ypos_q,    pix_ypos_d;
  logic        frame_start_q;
  logic        frame_done_q;
  logic        line_err_q;
  logic        frame_err_q;
  logic        locked_q,      locked_d;

  // Decoded events for the sample being processed this cycle.
  logic        de_rise;
  logic        de_fall;
  logic [15:0] gap_inc;
  logic        vblank_ev;
  logic [10:0] cur_x;
  logic [10:0] cur_x_inc;
  logic [10:0] vcnt_inc;
  logic        in_range;

  // FSM outputs for this cycle.
  logic        accept;
  logic        start_c;
  logic        frame_done_c;
  logic        line_err_c;
  logic        frame_err_c;

  // Register the panel bus; also keep the previous DE to find edges.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      rgb_q     <= 16'd0;
    end else begin
      de_q      <= lcd_de;
      de_prev_q <= de_q;
      rgb_q     <= lcd_rgb;
    end
  end

  // Edge detection, saturating increments and the vertical-blank decision.
  always_comb begin
    de_rise   = de_q & ~de_prev_q;
    de_fall   = ~de_q & de_prev_q;
    gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + 16'd1;
    // Fires only on the cycle the low run first reaches the threshold; once the
    // counter sits at or above it (or saturates) no further event is produced.
    vblank_ev = ~de_q & (gap_q != VBLANK_THR) & (gap_inc == VBLANK_THR);
    // Column of the sample being processed: a rising DE restarts the line.
    cur_x     = de_rise ? 11'd0 : hcnt_q;
    cur_x_inc = (cur_x == CNT_MAX) ? cur_x : cur_x + 11'd1;
    vcnt_inc  = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + 11'd1;
    in_range  = (cur_x < H_DISP) && (vcnt_q < V_DISP);
  end

  // Next-state values for the gap, column and line counters.
  always_comb begin
    gap_d  = de_q ? 16'd0 : gap_inc;
    hcnt_d = de_q ? cur_x_inc : hcnt_q;
    vcnt_d = vcnt_q;
    if (vblank_ev) begin
      vcnt_d = 11'd0;
    end else if (de_fall) begin
      vcnt_d = vcnt_inc;
    end
  end

  // Receiver FSM: decides pixel acceptance and boundary/error pulses.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    start_c      = 1'b0;
    frame_done_c = 1'b0;
    line_err_c   = 1'b0;
    frame_err_c  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vblank_ev) begin
          state_d = ST_VBLANK;
        end
      end
      ST_VBLANK: begin
        // vcnt was cleared by the blank event, so this is pixel (0,0).
        if (de_rise) begin
          state_d = ST_ACTIVE;
          accept  = in_range;
          start_c = in_range;
        end
      end
      ST_ACTIVE: begin
        if (de_q) begin
          accept = in_range;
        end else begin
          // ACTIVE is only ever entered on a DE-high sample, so low here is a fall.
          state_d    = ST_HBLANK;
          line_err_c = (hcnt_q != H_DISP);
        end
      end
      ST_HBLANK: begin
        if (de_q) begin
          state_d = ST_ACTIVE;
          accept  = in_range;
        end else if (vblank_ev) begin
          state_d      = ST_VBLANK;
          frame_done_c = 1'b1;
          frame_err_c  = (vcnt_q != V_DISP);
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Lock tracking: any error drops lock at once; a frame that ended without a
  // single error (line or frame) sets it when its frame_done fires.
  always_comb begin
    frame_bad_d = frame_bad_q;
    if (frame_done_c) begin
      frame_bad_d = 1'b0;
    end else if (line_err_c) begin
      frame_bad_d = 1'b1;
    end

    locked_d = locked_q;
    if (line_err_c || frame_err_c) begin
      locked_d = 1'b0;
    end else if (frame_done_c && !frame_bad_q) begin
      locked_d = 1'b1;
    end
  end

  // Pixel payload is only updated on accepted pixels and held otherwise.
  always_comb begin
    pix_data_d = pix_data_q;
    pix_xpos_d = pix_xpos_q;
    pix_ypos_d = pix_ypos_q;
    if (accept) begin
      pix_data_d = rgb_q;
      pix_xpos_d = cur_x;
      pix_ypos_d = vcnt_q;
    end
  end

  // Counter, state and output registers.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_q         <= 16'd0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 11'd0;
      state_q       <= ST_SEARCH;
      frame_bad_q   <= 1'b0;
      pix_data_q    <= 16'd0;
      pix_valid_q   <= 1'b0;
      pix_xpos_q    <= 11'd0;
      pix_ypos_q    <= 11'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      gap_q         <= gap_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      state_q       <= state_d;
      frame_bad_q   <= frame_bad_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= accept;
      pix_xpos_q    <= pix_xpos_d;
      pix_ypos_q    <= pix_ypos_d;
      frame_start_q <= start_c;
      frame_done_q  <= frame_done_c;
      line_err_q    <= line_err_c;
      frame_err_q   <= frame_err_c;
      locked_q      <= locked_d;
    end
  end

`ifdef LCD_RX_CHECKSUM_EN
  logic [15:0] sum_q,       sum_d;
  logic [15:0] frame_sum_q, frame_sum_d;

  // Running sum restarts with the first pixel of a frame; the finished value
  // is published on frame_done and held until the next one.
  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = start_c ? rgb_q : sum_q + rgb_q;
    end
    frame_sum_d = frame_done_c ? sum_q : frame_sum_q;
  end

  // Checksum registers.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_q       <= 16'd0;
      frame_sum_q <= 16'd0;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'd0;
`endif

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_xpos    = pix_xpos_q;
  assign pix_ypos    = pix_ypos_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_lcd_de_rx_timing.sv
// tb_lcd_de_rx_timing
// Directed bench for lcd_de_rx_timing using a reduced raster (8x4 active,
// blank threshold 20) so several frames fit in a short run. Every expected
// pixel is queued by the stimulus with its coordinates, data and due cycle.

module tb_lcd_de_rx_timing;

  localparam int HI  = 8;   // active pixels per line
  localparam int VI  = 4;   // active lines per frame
  localparam int THR = 20;  // vertical blank threshold
  localparam int HB  = 6;   // horizontal blank (below THR)
  localparam int VB  = 30;  // vertical blank (above THR)

  logic        lcd_clk = 1'b0;
  logic        sys_rst_n;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [10:0] pix_xpos;
  logic [10:0] pix_ypos;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;
  logic        locked;
  logic [15:0] frame_sum;

  lcd_de_rx_timing #(
    .H_DISP    (11'(HI)),
    .V_DISP    (11'(VI)),
    .VBLANK_THR(16'(THR))
  ) dut (
    .lcd_clk    (lcd_clk),
    .sys_rst_n  (sys_rst_n),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_xpos   (pix_xpos),
    .pix_ypos   (pix_ypos),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .locked     (locked),
    .frame_sum  (frame_sum)
  );

  always #5 lcd_clk = ~lcd_clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] d;
    logic        s;
    logic [31:0] due;
  } pix_t;

  pix_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          valid_cnt, fs_cnt, fd_cnt, le_cnt, fe_cnt;
  logic [31:0] cyc = 0;
  logic [15:0] psum = 16'd0;

  function automatic logic [15:0] exp_fsum();
`ifdef LCD_RX_CHECKSUM_EN
    return psum;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clr_cnt();
    valid_cnt = 0; fs_cnt = 0; fd_cnt = 0; le_cnt = 0; fe_cnt = 0;
  endtask

  // Look at the outputs after an edge: match pixels against the queue and tally pulses.
  task automatic observe();
    pix_t e;
    if (pix_valid) begin
      valid_cnt++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pix observed x=%0d y=%0d expected no pixel", pix_xpos, pix_ypos);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        assert ({pix_xpos, pix_ypos, pix_data, frame_start, cyc} === {e.x, e.y, e.d, e.s, e.due}) else begin
          fails++;
          $error("FAIL pix observed x=%0d y=%0d d=%h fs=%0b cyc=%0d expected x=%0d y=%0d d=%h fs=%0b cyc=%0d",
                 pix_xpos, pix_ypos, pix_data, frame_start, cyc, e.x, e.y, e.d, e.s, e.due);
        end
      end
    end
    if (frame_start) fs_cnt++;
    if (line_err)    le_cnt++;
    if (frame_err)   fe_cnt++;
    if (frame_done) begin
      fd_cnt++;
      tests++;
      assert (frame_sum === exp_fsum()) else begin
        fails++;
        $error("FAIL frame_sum observed=%h expected=%h", frame_sum, exp_fsum());
      end
    end
  endtask

  // Drive one bus cycle; acc marks a pixel the receiver must deliver next cycle.
  task automatic step(input logic de, input logic [15:0] rgb, input logic acc,
                      input logic [10:0] x, input logic [10:0] y, input logic st);
    pix_t e;
    lcd_de  = de;
    lcd_rgb = rgb;
    if (acc) begin
      e.x = x; e.y = y; e.d = rgb; e.s = st; e.due = cyc + 32'd2;
      exp_q.push_back(e);
    end
    @(posedge lcd_clk);
    cyc = cyc + 32'd1;
    #1;
    observe();
    if (acc) psum = st ? rgb : psum + rgb;
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 11'd0, 11'd0, 1'b0);
  endtask

  task automatic line(input int y, input int npix, input logic armed, input logic ones);
    logic [7:0]  yb;
    logic [7:0]  xb;
    logic [15:0] rgb;
    for (int x = 0; x < npix; x++) begin
      yb  = y[7:0];
      xb  = x[7:0];
      rgb = ones ? 16'h0001 : {yb ^ 8'h5A, xb};
      step(1'b1, rgb, armed && (x < HI) && (y < VI), x[10:0], y[10:0], (x == 0) && (y == 0));
    end
  endtask

  task automatic frame(input int nl, input int npix, input logic ones);
    for (int y = 0; y < nl; y++) begin
      line(y, npix, 1'b1, ones);
      if (y < nl - 1) low(HB);
    end
    low(VB);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    lcd_de    = 1'b0;
    lcd_rgb   = 16'h0000;
    clr_cnt();
    repeat (3) @(posedge lcd_clk);
    #1;
    tests++;
    assert ({pix_data, pix_valid, pix_xpos, pix_ypos, frame_start, frame_done, line_err,
             frame_err, locked, frame_sum} === 60'd0) else begin
      fails++;
      $error("FAIL reset_outputs observed=%h expected=0", {pix_data, pix_valid, pix_xpos, pix_ypos,
             frame_start, frame_done, line_err, frame_err, locked, frame_sum});
    end
    sys_rst_n = 1'b1;

    // 1) first blank seen in SEARCH gives no frame_done, then three clean frames
    low(VB);
    chk("search_no_frame_done", fd_cnt, 0);
    for (int y = 0; y < VI; y++) begin
      line(y, HI, 1'b1, 1'b0);
      if (y < VI - 1) low(HB);
    end
    chk("locked_before_first_done", int'(locked), 0);
    low(VB);
    chk("locked_after_first_frame", int'(locked), 1);
    frame(VI, HI, 1'b0);
    frame(VI, HI, 1'b0);
    chk("t1_valid", valid_cnt, 3 * HI * VI);
    chk("t1_frame_start", fs_cnt, 3);
    chk("t1_frame_done", fd_cnt, 3);
    chk("t1_errors", le_cnt + fe_cnt, 0);
    chk("t1_locked", int'(locked), 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    $display("[TB] clean frames: valid=%0d done=%0d", valid_cnt, fd_cnt);

    // 2) short line then long line: two line errors, lock lost for the frame
    clr_cnt();
    line(0, HI, 1'b1, 1'b0);     low(HB);
    line(1, HI - 1, 1'b1, 1'b0); low(HB);
    chk("t2_line_err_short", le_cnt, 1);
    chk("t2_locked_drop", int'(locked), 0);
    line(2, HI + 1, 1'b1, 1'b0); low(HB);
    line(3, HI, 1'b1, 1'b0);     low(VB);
    chk("t2_line_err_total", le_cnt, 2);
    chk("t2_frame_err", fe_cnt, 0);
    chk("t2_frame_done", fd_cnt, 1);
    chk("t2_locked_stays_low", int'(locked), 0);
    chk("t2_valid", valid_cnt, 4 * HI - 1);

    // 3) one extra line: not accepted, frame error, then a clean frame re-locks
    clr_cnt();
    frame(VI + 1, HI, 1'b0);
    chk("t3_frame_err", fe_cnt, 1);
    chk("t3_locked_low", int'(locked), 0);
    chk("t3_valid", valid_cnt, HI * VI);
    frame(VI, HI, 1'b0);
    chk("t3_relock", int'(locked), 1);
    chk("t3_frame_err_once", fe_cnt, 1);
    chk("t3_line_err", le_cnt, 0);

    // 4) reset mid-line clears everything; nothing until the next blank
    clr_cnt();
    line(0, HI, 1'b1, 1'b0); low(HB);
    line(1, HI, 1'b1, 1'b0); low(HB);
    line(2, 4, 1'b1, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    tests++;
    assert ({pix_data, pix_valid, pix_xpos, pix_ypos, frame_start, frame_done, line_err,
             frame_err, locked, frame_sum} === 60'd0) else begin
      fails++;
      $error("FAIL midline_reset observed=%h expected=0", {pix_data, pix_valid, pix_xpos, pix_ypos,
             frame_start, frame_done, line_err, frame_err, locked, frame_sum});
    end
    exp_q.delete();
    clr_cnt();
    step(1'b1, 16'h1234, 1'b0, 11'd0, 11'd0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 11'd0, 11'd0, 1'b0);
    sys_rst_n = 1'b1;
    line(2, 4, 1'b0, 1'b0); low(HB);
    line(3, HI, 1'b0, 1'b0); low(VB);
    chk("t4_no_pix_in_search", valid_cnt, 0);
    chk("t4_no_done_in_search", fd_cnt, 0);
    chk("t4_no_err_in_search", le_cnt + fe_cnt, 0);
    frame(VI, HI, 1'b0);
    chk("t4_frame_start", fs_cnt, 1);
    chk("t4_valid", valid_cnt, HI * VI);
    chk("t4_locked", int'(locked), 1);

    // 5) low run of THR-1 is still horizontal blank; exactly THR is a frame end
    clr_cnt();
    line(0, HI, 1'b1, 1'b0); low(THR - 1);
    line(1, HI, 1'b1, 1'b0);
    chk("t5_gap_thr_minus1", fd_cnt, 0);
    low(HB); line(2, HI, 1'b1, 1'b0);
    low(HB); line(3, HI, 1'b1, 1'b0);
    low(THR);
    line(0, HI, 1'b1, 1'b0);
    chk("t5_gap_thr_done", fd_cnt, 1);
    chk("t5_frame_err", fe_cnt, 0);
    for (int y = 1; y < VI; y++) begin
      low(HB);
      line(y, HI, 1'b1, 1'b0);
    end
    low(VB);
    chk("t5_frame_done_total", fd_cnt, 2);
    chk("t5_valid", valid_cnt, 2 * HI * VI);
    chk("t5_locked", int'(locked), 1);

    // 6) all-ones frame: checksum equals pixel count (zero without the feature)
    clr_cnt();
    frame(VI, HI, 1'b1);
    low(5);
`ifdef LCD_RX_CHECKSUM_EN
    chk("t6_frame_sum", int'(frame_sum), HI * VI);
`else
    chk("t6_frame_sum", int'(frame_sum), 0);
`endif
    chk("t6_frame_done", fd_cnt, 1);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
